// File: rtl/vm_pkg.sv
// Shared definitions for the vend dispense path:
// request codes, FSM encoding and parameter defaults.
`timescale 1ns/1ps
package vm_pkg;

  localparam logic [1:0] TEA    = 2'd1;
  localparam logic [1:0] COFFEE = 2'd2;
  localparam logic [1:0] CHANGE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT_DROP,
    S_FAULT
  } state_t;

  localparam int MOTOR_CYCLES_DEF   = 8;
  localparam int CHANGE_CYCLES_DEF  = 4;
  localparam int TIMEOUT_CYCLES_DEF = 32;
  localparam int FIFO_DEPTH         = 4;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dispense_fifo.sv
// 4-entry request queue with two ordered write ports;
// writes beyond free space are dropped, port 1 first.
`timescale 1ns/1ps
module dispense_fifo
  import vm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr0_en_i,
  input  logic [1:0] wr0_data_i,
  input  logic       wr1_en_i,
  input  logic [1:0] wr1_data_i,
  input  logic       rd_en_i,
  output logic [1:0] rd_data_o,
  output logic [2:0] count_o,
  output logic       drop_o
);

  logic [1:0] mem_q [FIFO_DEPTH];
  logic [1:0] rp_q;
  logic [1:0] wp_q;
  logic [2:0] cnt_q;
  logic [2:0] free;
  logic [1:0] wp1;
  logic       acc0;
  logic       acc1;

  // A pop on the same edge frees its slot for this cycle's writes.
  always_comb begin
    free = 3'(FIFO_DEPTH) - cnt_q + {2'b0, rd_en_i};
    acc0 = wr0_en_i && (free >= 3'd1);
    acc1 = wr1_en_i && (free >= 3'd2);
    wp1  = wp_q + 2'd1;
  end

  assign drop_o    = (wr0_en_i & ~acc0) | (wr1_en_i & ~acc1);
  assign rd_data_o = mem_q[rp_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (acc0) mem_q[wp_q] <= wr0_data_i;
      if (acc1) mem_q[wp1]  <= wr1_data_i;
      if (rd_en_i) rp_q <= rp_q + 2'd1;
      wp_q  <= wp_q + {1'b0, acc0} + {1'b0, acc1};
      cnt_q <= cnt_q + {2'b0, acc0} + {2'b0, acc1}
             - {2'b0, rd_en_i};
    end
  end

endmodule

// File: rtl/dispense_controller.sv
// Vend dispense controller: queues vend/change requests
// and sequences motors, change solenoid and drop check.
`timescale 1ns/1ps
module dispense_controller
  import vm_pkg::*;
#(
  parameter int MOTOR_CYCLES   = MOTOR_CYCLES_DEF,
  parameter int CHANGE_CYCLES  = CHANGE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic deliver_tea,
  input  logic deliver_coffee,
  input  logic change,
  input  logic drop_sense,
  input  logic fault_clr,
  output logic tea_motor,
  output logic coffee_motor,
  output logic change_sol,
  output logic vend_done,
  output logic busy,
  output logic fault,
  output logic overflow
);

  localparam int CW =
    $clog2(max3(MOTOR_CYCLES, CHANGE_CYCLES, TIMEOUT_CYCLES) + 1);

  logic          tea_q;
  logic          cof_q;
  logic          chg_q;
  logic          ds1_q;
  logic          ds2_q;
  logic          ovf_q;
  state_t        state_q;
  state_t        state_d;
  logic [1:0]    code_q;
  logic [1:0]    code_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          done_q;
  logic          done_d;

  logic          prod_v;
  logic          wr0_en;
  logic          wr1_en;
  logic [1:0]    wr0_data;
  logic          pop;
  logic [1:0]    head;
  logic [2:0]    count;
  logic          drop;

  // One product entry per cycle, always ahead of a change entry.
  assign prod_v   = tea_q | cof_q;
  assign wr0_en   = prod_v | chg_q;
  assign wr0_data = tea_q ? TEA : (cof_q ? COFFEE : CHANGE);
  assign wr1_en   = prod_v & chg_q;

  dispense_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .wr0_en_i   (wr0_en),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_data_i (CHANGE),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .count_o    (count),
    .drop_o     (drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tea_q   <= 1'b0;
      cof_q   <= 1'b0;
      chg_q   <= 1'b0;
      ds1_q   <= 1'b0;
      ds2_q   <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      tea_q   <= deliver_tea;
      cof_q   <= deliver_coffee;
      chg_q   <= change;
      ds1_q   <= drop_sense;
      ds2_q   <= ds1_q;
      ovf_q   <= ovf_q | drop;
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count != 3'd0) begin
          pop     = 1'b1;
          code_d  = head;
          cnt_d   = (head == CHANGE) ? CW'(CHANGE_CYCLES - 1)
                                     : CW'(MOTOR_CYCLES - 1);
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          if (code_q == CHANGE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = CW'(TIMEOUT_CYCLES - 1);
            state_d = S_WAIT_DROP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_DROP: begin
        if (ds2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tea_motor    = (state_q == S_DRIVE) && (code_q == TEA);
  assign coffee_motor = (state_q == S_DRIVE) && (code_q == COFFEE);
  assign change_sol   = (state_q == S_DRIVE) && (code_q == CHANGE);
  assign vend_done    = done_q;
  assign busy         = (state_q != S_IDLE) || (count != 3'd0);
  assign fault        = (state_q == S_FAULT);
  assign overflow     = ovf_q;

endmodule

// File: doc/dispense_controller.md
DISPENSE_CONTROLLER -- requirements
Module: dispense_controller

Interface
REQ-001 SHALL have parameter MOTOR_CYCLES, default 8: cycles a product motor is driven per vend (min 1).
REQ-002 SHALL have parameter CHANGE_CYCLES, default 4: cycles the change solenoid is driven per coin return (min 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32: max cycles to wait for drop_sense after a motor run.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port deliver_tea  input  1  single-cycle tea vend request from vending_machine.
REQ-007 SHALL have port deliver_coffee  input  1  single-cycle coffee vend request from vending_machine.
REQ-008 SHALL have port change  input  1  single-cycle coin-return request from vending_machine.
REQ-009 SHALL have port drop_sense  input  1  asynchronous chute sensor, high while an item falls.
REQ-010 SHALL have port fault_clr  input  1  single-cycle service clear of fault.
REQ-011 SHALL have ports tea_motor, coffee_motor, change_sol  output  1 each  actuator drives.
REQ-012 SHALL have port vend_done  output  1  single-cycle pulse per completed vend or change.
REQ-013 SHALL have ports busy  output  1 (FSM not IDLE or queue non-empty), fault  output  1 (sticky), overflow  output  1 (sticky).

Function
REQ-014 SHALL queue requests in a 4-entry FIFO of 2-bit codes: TEA=1, COFFEE=2, CHANGE=3.
REQ-015 SHALL accept up to two writes per cycle; product entry (tea before coffee if both asserted) written before CHANGE.
REQ-016 Writes exceeding free space SHALL be discarded, lowest priority last written first dropped, and set overflow; queued entries unaffected.
REQ-017 SHALL synchronise drop_sense through two flops before use.
REQ-018 FSM states: IDLE, DRIVE, WAIT_DROP, FAULT.
REQ-019 IDLE: if FIFO non-empty and not fault, pop head, load counter, go DRIVE; asserted actuator registered, active first cycle in DRIVE.
REQ-020 From empty/IDLE, actuator SHALL assert on the second rising edge after the edge sampling the request pulse.
REQ-021 DRIVE holds exactly one actuator high for MOTOR_CYCLES (product) or CHANGE_CYCLES (CHANGE) cycles.
REQ-022 DRIVE end: product -> WAIT_DROP; CHANGE -> IDLE with vend_done pulsed one cycle.
REQ-023 WAIT_DROP: synchronised drop_sense high -> vend_done pulse, go IDLE; TIMEOUT_CYCLES elapsed without it -> FAULT.
REQ-024 FAULT: all actuators low, fault=1, FIFO retained and still accepting; fault_clr -> IDLE, fault=0.
REQ-025 fault_clr outside FAULT SHALL have no effect; overflow cleared only by reset.
REQ-026 Actuators SHALL be mutually exclusive every cycle; no actuator high outside DRIVE.
REQ-027 drop_sense outside WAIT_DROP SHALL be ignored.
REQ-028 Request arriving same cycle as pop SHALL be enqueued correctly (simultaneous read/write at full or empty).

Reset
REQ-029 rst low SHALL immediately force IDLE, empty FIFO, counters 0, all outputs 0, synchroniser flops 0.
REQ-030 Reset mid-DRIVE SHALL drop actuators asynchronously; queued requests lost.
REQ-031 Operation SHALL resume on first rising edge after rst deasserts.

Structure
REQ-032 Shared package vm_pkg SHALL hold request code constants (TEA, COFFEE, CHANGE), FSM state encoding and parameter defaults.
REQ-033 FIFO SHALL be sub-module dispense_fifo (depth 4, 2-bit data, dual write port, count output).

Verification
REQ-034 deliver_tea pulse, drop_sense high 3 cycles after motor falls -> tea_motor high 8 cycles starting 2 edges after pulse, one vend_done, busy low after.
REQ-035 deliver_coffee and change same cycle -> coffee_motor 8 cycles, drop, then change_sol 4 cycles, two vend_done pulses, never overlapping.
REQ-036 deliver_tea with drop_sense held low -> FAULT 32 cycles after motor falls, fault=1; pulse fault_clr -> IDLE, next queued request served.
REQ-037 Six back-to-back requests during one long vend -> 4 queued, overflow=1, exactly 4 (plus active) vends executed in order.
REQ-038 rst low mid-DRIVE with 2 queued -> actuators low same cycle, busy 0, no vend after rst released.
